tlight_multi: RTL and testbench
===============================

// Module: tlight_multi
// PURPOSE
//  Parametrised N-approach traffic-light controller; successor of the fixed two-way WE/NS controller.
//  Rotates green round-robin over N_DIR approaches with configurable phase lengths, optional all-red clearance,
//  latched per-approach pedestrian requests that extend green, and a night mode with all lamps flashing yellow.
//  Top-level junction controller; drives lamp heads directly.
// PARAMETERS
//  N_DIR        2   number of approaches (>=2); dir0 = WE, dir1 = NS for legacy compatibility
//  READY_CYC    3   cycles in READY (yellow before green), >=1
//  GO_CYC       15  cycles in GO (green), >=1
//  STOP_CYC     1   cycles in STOP (yellow after green), >=1
//  ALLRED_CYC   0   all-red clearance cycles after STOP; 0 = state skipped
//  PED_EXT_CYC  5   extra GO cycles when a pedestrian request is served
//  FLASH_CYC    1   night-mode half-period in cycles, >=1
// PORTS
//  clock       in   1                 system clock
//  reset_n     in   1                 asynchronous reset, active-low
//  night_mode  in   1                 level; request flashing-yellow operation
//  ped_req     in   N_DIR             per-approach pedestrian request, pulse or level
//  lights      out  tlight_control_t [N_DIR]  lamp per approach
//  ped_walk    out  N_DIR             walk signal per approach
//  active_dir  out  DIR_W=$clog2(N_DIR)  approach owning current phase
//  phase       out  tlight_phase_t    current controller phase
// BEHAVIOUR
//  - One clock; async active-low reset. In reset: phase=RESET, active_dir=0, lights all RED, ped_walk=0,
//    timer=0, ped_pending=0. All outputs are a Moore decode of registered state, valid in the same cycle.
//  - Phases: RESET, READY, GO, STOP, ALLRED, NIGHT. Each timed phase lasts exactly its parameter count:
//    timer loaded with (len-1) on entry, phase advances the cycle after timer==0.
//  - RESET: 1 cycle after reset release -> READY, active_dir=0.
//  - READY -> GO -> STOP -> ALLRED (skipped if ALLRED_CYC==0) -> READY with active_dir=(d+1) mod N_DIR.
//  - Lamps: active dir YELLOW in READY/STOP, GREEN in GO; all other dirs RED. RESET/ALLRED all RED.
//    Invariant: never more than one approach non-RED outside NIGHT.
//  - Ped: ped_req[i] sets ped_pending[i]. On entry to GO of d, if (ped_pending[d]|ped_req[d]):
//    GO length = GO_CYC+PED_EXT_CYC, ped_walk[d]=1 for the whole GO, ped_pending[d] cleared.
//    ped_req[d] during a served GO of d is dropped. ped_walk is 0 in all other phases.
//  - Night entry: night_mode sampled only at the end of the clearance (last ALLRED cycle, or last STOP
//    cycle if ALLRED_CYC==0); if high -> NIGHT instead of READY. Never entered mid READY/GO.
//    ped_pending cleared on entry; ped_req ignored in NIGHT.
//  - NIGHT: all lamps YELLOW for FLASH_CYC, then OFF for FLASH_CYC, repeating, starting YELLOW.
//    night_mode low on any cycle -> next cycle RESET (all RED 1 cycle) -> READY dir0.
//  - Timer width TIMER_W = $clog2(max(READY,GO+PED_EXT,STOP,ALLRED,FLASH)+1); no wrap.
//  - reset_n assertion at any time forces reset values immediately (asynchronously).
//  - Defaults (N_DIR=2, ALLRED_CYC=0) reproduce the legacy WE/NS sequence and timing exactly.
//  - Elaboration error if N_DIR<2 or any *_CYC (except ALLRED_CYC, PED_EXT_CYC) < 1.
// STRUCTURE
//  - tlight_package: add tlight_phase_t {RESET,READY,GO,STOP,ALLRED,NIGHT}; append OFF to
//    tlight_control_t after existing values (RED/YELLOW/GREEN encodings unchanged).
//  - Sub-module tlight_phase_timer: loadable down-counter (load, load_val, done), TIMER_W wide.
// TESTING
//  1. Defaults, release reset -> RESET 1 cyc; dir0 YELLOW 3, GREEN 15, YELLOW 1; dir1 YELLOW 3, GREEN 15...
//  2. N_DIR=3, ALLRED_CYC=2 -> order 0,1,2,0; 2 all-RED cycles between; assert one non-RED lamp max.
//  3. 1-cycle ped_req[1] during dir0 GO -> dir1 GO 20 cyc with ped_walk[1]=1 all 20; next dir1 GO 15, walk 0.
//  4. night_mode high mid dir0 GO -> GO/STOP complete, then NIGHT: all YELLOW 1, OFF 1, alternating.
//  5. night_mode low in NIGHT -> 1 cycle all RED (RESET), then dir0 READY; pending ped reqs gone.
//  6. reset_n low mid dir1 GO -> all RED, ped_walk=0, active_dir=0 immediately; after release RESET 1 cyc.

Source files
------------

// File: rtl/tlight_package.sv
// Shared types for the junction controller: lamp encodings, controller phases, elaboration helpers.
// Type-only package; no logic, no latency, no flow control.
package tlight_package;

  // RED/YELLOW/GREEN keep their legacy encodings; OFF is only used by the night flash.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    OFF    = 2'd3
  } tlight_control_t;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    READY  = 3'd1,
    GO     = 3'd2,
    STOP   = 3'd3,
    ALLRED = 3'd4,
    NIGHT  = 3'd5
  } tlight_phase_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlight_phase_timer.sv
// Loadable down-counter that times one controller phase; saturates at zero, done while zero.
// Load takes effect on the next edge; never stalls.
module tlight_phase_timer #(
  parameter int TIMER_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tlight_multi.sv
// N-approach round-robin traffic-light controller with ped extension, all-red clearance and night flash.
// Outputs are a Moore decode of registered state (valid the same cycle); no backpressure.
module tlight_multi
  import tlight_package::*;
#(
  parameter int  N_DIR       = 2,
  parameter int  READY_CYC   = 3,
  parameter int  GO_CYC      = 15,
  parameter int  STOP_CYC    = 1,
  parameter int  ALLRED_CYC  = 0,
  parameter int  PED_EXT_CYC = 5,
  parameter int  FLASH_CYC   = 1,
  localparam int DIR_W       = $clog2(N_DIR)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        night_mode,
  input  logic [N_DIR-1:0]            ped_req,
  output tlight_control_t [N_DIR-1:0] lights,
  output logic [N_DIR-1:0]            ped_walk,
  output logic [DIR_W-1:0]            active_dir,
  output tlight_phase_t               phase
);

  localparam int MAX_LEN = max_of(max_of(READY_CYC, GO_CYC + PED_EXT_CYC),
                                  max_of(max_of(STOP_CYC, ALLRED_CYC), FLASH_CYC));
  localparam int TIMER_W = $clog2(MAX_LEN + 1);

  localparam logic [TIMER_W-1:0] LD_READY  = TIMER_W'(READY_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_GO     = TIMER_W'(GO_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_GO_PED = TIMER_W'(GO_CYC + PED_EXT_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_STOP   = TIMER_W'(STOP_CYC - 1);
  localparam logic [TIMER_W-1:0] LD_ALLRED = TIMER_W'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
  localparam logic [TIMER_W-1:0] LD_FLASH  = TIMER_W'(FLASH_CYC - 1);

  if (N_DIR < 2) begin : g_bad_ndir
    $error("tlight_multi: N_DIR must be at least 2");
  end
  if (READY_CYC < 1 || GO_CYC < 1 || STOP_CYC < 1 || FLASH_CYC < 1 ||
      ALLRED_CYC < 0 || PED_EXT_CYC < 0) begin : g_bad_cyc
    $error("tlight_multi: phase lengths out of range");
  end

  tlight_phase_t      phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [N_DIR-1:0]   pend_q, pend_d;
  logic               walk_q, walk_d;
  logic               flash_off_q, flash_off_d;
  logic               tmr_load, tmr_done, clr_end;
  logic [TIMER_W-1:0] tmr_val;

  tlight_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= RESET;
      dir_q       <= '0;
      pend_q      <= '0;
      walk_q      <= 1'b0;
      flash_off_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      walk_q      <= walk_d;
      flash_off_q <= flash_off_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    dir_d       = dir_q;
    pend_d      = pend_q;
    walk_d      = walk_q;
    flash_off_d = flash_off_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    clr_end     = 1'b0;

    // A request for the approach whose walk is already showing is simply absorbed.
    if (phase_q != NIGHT) pend_d = pend_q | ped_req;
    if (phase_q == GO && walk_q) pend_d[dir_q] = 1'b0;

    case (phase_q)
      RESET: begin
        phase_d  = READY;
        dir_d    = '0;
        tmr_load = 1'b1;
        tmr_val  = LD_READY;
      end
      READY: if (tmr_done) begin
        phase_d        = GO;
        walk_d         = pend_q[dir_q] | ped_req[dir_q];
        pend_d[dir_q]  = 1'b0;
        tmr_load       = 1'b1;
        tmr_val        = walk_d ? LD_GO_PED : LD_GO;
      end
      GO: if (tmr_done) begin
        phase_d  = STOP;
        walk_d   = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = LD_STOP;
      end
      STOP: if (tmr_done) begin
        if (ALLRED_CYC > 0) begin
          phase_d  = ALLRED;
          tmr_load = 1'b1;
          tmr_val  = LD_ALLRED;
        end else begin
          clr_end = 1'b1;
        end
      end
      ALLRED: if (tmr_done) clr_end = 1'b1;
      NIGHT: begin
        if (!night_mode) begin
          phase_d = RESET;
          dir_d   = '0;
        end else if (tmr_done) begin
          flash_off_d = ~flash_off_q;
          tmr_load    = 1'b1;
          tmr_val     = LD_FLASH;
        end
      end
      default: phase_d = RESET;
    endcase

    // Night mode is only honoured once the junction is fully cleared.
    if (clr_end) begin
      tmr_load = 1'b1;
      if (night_mode) begin
        phase_d     = NIGHT;
        pend_d      = '0;
        flash_off_d = 1'b0;
        tmr_val     = LD_FLASH;
      end else begin
        phase_d = READY;
        dir_d   = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
        tmr_val = LD_READY;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_DIR; i++) begin
      lights[i]   = RED;
      ped_walk[i] = 1'b0;
      if (phase_q == NIGHT) begin
        lights[i] = flash_off_q ? OFF : YELLOW;
      end else if (DIR_W'(i) == dir_q) begin
        if (phase_q == READY || phase_q == STOP) begin
          lights[i] = YELLOW;
        end else if (phase_q == GO) begin
          lights[i]   = GREEN;
          ped_walk[i] = walk_q;
        end
      end
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_tlight_multi.sv
// Bench for tlight_multi: a legacy-default instance and a 3-way all-red instance, each checked every
// cycle against a phase-schedule model, plus hand-computed pins on the key transitions.
module tb_tlight_multi;
  import tlight_package::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic night0 = 1'b0, night1 = 1'b0;
  logic [1:0] ped0 = '0;
  logic [2:0] ped1 = '0;

  tlight_control_t [1:0] lights0;
  tlight_control_t [2:0] lights1;
  logic [1:0] walk0;
  logic [2:0] walk1;
  logic [0:0] dir0;
  logic [1:0] dir1;
  tlight_phase_t phase0, phase1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tlight_multi u0 (
    .clock(clock), .reset_n(reset_n), .night_mode(night0), .ped_req(ped0),
    .lights(lights0), .ped_walk(walk0), .active_dir(dir0), .phase(phase0)
  );

  tlight_multi #(
    .N_DIR(3), .READY_CYC(2), .GO_CYC(4), .STOP_CYC(1),
    .ALLRED_CYC(2), .PED_EXT_CYC(3), .FLASH_CYC(2)
  ) u1 (
    .clock(clock), .reset_n(reset_n), .night_mode(night1), .ped_req(ped1),
    .lights(lights1), .ped_walk(walk1), .active_dir(dir1), .phase(phase1)
  );

  // Per-instance configuration and schedule model: phase, owner, cycles spent vs. phase length.
  int c_n[2]    = '{2, 3};
  int c_rdy[2]  = '{3, 2};
  int c_go[2]   = '{15, 4};
  int c_stop[2] = '{1, 1};
  int c_ar[2]   = '{0, 2};
  int c_ext[2]  = '{5, 3};
  int c_fl[2]   = '{1, 2};

  tlight_phase_t m_ph[2];
  int            m_dir[2], m_age[2], m_len[2];
  bit            m_walk[2], m_off[2];
  bit [3:0]      m_pend[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic enter(input int k, input tlight_phase_t p, input int len);
    m_ph[k]  = p;
    m_age[k] = 1;
    m_len[k] = len;
  endtask

  task automatic mstep(input int k, input bit rst_ok, input bit night, input bit [3:0] req);
    bit served;
    if (!rst_ok) begin
      m_ph[k] = RESET; m_dir[k] = 0; m_age[k] = 1; m_len[k] = 1;
      m_walk[k] = 0; m_off[k] = 0; m_pend[k] = '0;
      return;
    end
    if (m_ph[k] != NIGHT) m_pend[k] = m_pend[k] | req;
    if (m_ph[k] == GO && m_walk[k]) m_pend[k][m_dir[k]] = 1'b0;
    if (m_ph[k] == RESET) begin
      m_dir[k] = 0;
      enter(k, READY, c_rdy[k]);
    end else if (m_ph[k] == NIGHT) begin
      if (!night) begin
        m_dir[k] = 0;
        enter(k, RESET, 1);
      end else if (m_age[k] == c_fl[k]) begin
        m_off[k] = !m_off[k];
        m_age[k] = 1;
      end else begin
        m_age[k]++;
      end
    end else if (m_age[k] < m_len[k]) begin
      m_age[k]++;
    end else if (m_ph[k] == READY) begin
      served = m_pend[k][m_dir[k]];
      m_pend[k][m_dir[k]] = 1'b0;
      m_walk[k] = served;
      enter(k, GO, c_go[k] + (served ? c_ext[k] : 0));
    end else if (m_ph[k] == GO) begin
      m_walk[k] = 0;
      enter(k, STOP, c_stop[k]);
    end else if (m_ph[k] == STOP && c_ar[k] > 0) begin
      enter(k, ALLRED, c_ar[k]);
    end else if (night) begin
      m_pend[k] = '0;
      m_off[k]  = 0;
      enter(k, NIGHT, c_fl[k]);
    end else begin
      m_dir[k] = (m_dir[k] + 1) % c_n[k];
      enter(k, READY, c_rdy[k]);
    end
  endtask

  function automatic logic [7:0] exp_lights(input int k);
    logic [7:0] v;
    logic [1:0] l;
    v = '0;
    for (int i = 0; i < c_n[k]; i++) begin
      l = RED;
      if (m_ph[k] == NIGHT) l = m_off[k] ? OFF : YELLOW;
      else if (i == m_dir[k] && (m_ph[k] == READY || m_ph[k] == STOP)) l = YELLOW;
      else if (i == m_dir[k] && m_ph[k] == GO) l = GREEN;
      v[2*i +: 2] = l;
    end
    return v;
  endfunction

  task automatic cmp(input int k, input tlight_phase_t aph, input int adir,
                     input logic [7:0] al, input logic [3:0] aw);
    int nonred;
    logic [3:0] ew;
    ew = (m_ph[k] == GO && m_walk[k]) ? (4'b0001 << m_dir[k]) : 4'b0000;
    chk($sformatf("u%0d_phase", k), aph, m_ph[k]);
    if (m_ph[k] != NIGHT) chk($sformatf("u%0d_dir", k), adir, m_dir[k]);
    chk($sformatf("u%0d_lights", k), al, exp_lights(k));
    chk($sformatf("u%0d_walk", k), aw, ew);
    if (aph != NIGHT) begin
      nonred = 0;
      for (int i = 0; i < c_n[k]; i++) if (al[2*i +: 2] != RED) nonred++;
      chk($sformatf("u%0d_one_lamp", k), (nonred <= 1), 1);
    end
  endtask

  always @(posedge clock) begin
    mstep(0, reset_n, night0, {2'b00, ped0});
    mstep(1, reset_n, night1, {1'b0, ped1});
    #1;
    cmp(0, phase0, dir0, {4'b0000, lights0}, {2'b00, walk0});
    cmp(1, phase1, dir1, {2'b00, lights1}, {1'b0, walk1});
  end

  initial begin
    @(negedge clock);
    chk("rst_phase0", phase0, RESET);
    chk("rst_lights0", lights0, 4'b0000);
    chk("rst_walk1", walk1, 3'b000);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      case (k)
        1:   begin chk("k1_ph0", phase0, READY); chk("k1_l0", lights0[0], YELLOW); end
        3:   begin chk("k3_ph0", phase0, READY); chk("k3_ph1", phase1, GO); end
        4:   begin chk("k4_ph0", phase0, GO); chk("k4_l0", lights0[0], GREEN); end
        5:   ped1 = 3'b100;
        6:   ped1 = 3'b000;
        7:   chk("k7_ph1", phase1, STOP);
        8:   begin chk("k8_ph1", phase1, ALLRED); chk("k8_l1", lights1, 6'b000000); end
        10:  begin chk("k10_dir1", dir1, 2'd1); chk("k10_ph1", phase1, READY); ped0 = 2'b10; end
        11:  ped0 = 2'b00;
        18:  chk("k18_ph0", phase0, GO);
        19:  chk("k19_ph0", phase0, STOP);
        20:  begin chk("k20_dir0", dir0, 1'b1); chk("k20_l0", lights0, 4'b0100); end
        21:  begin chk("k21_ph1", phase1, GO); chk("k21_w1", walk1, 3'b100); end
        23:  begin chk("k23_ph0", phase0, GO); chk("k23_w0", walk0, 2'b10); end
        27:  chk("k27_w1", walk1, 3'b100);
        28:  chk("k28_ph1", phase1, STOP);
        31:  begin chk("k31_ph1", phase1, READY); chk("k31_dir1", dir1, 2'd0); end
        40:  night1 = 1'b1;
        42:  begin chk("k42_ph0", phase0, GO); chk("k42_w0", walk0, 2'b10); end
        43:  begin chk("k43_ph0", phase0, STOP); chk("k43_w0", walk0, 2'b00); end
        48:  chk("k48_ph1", phase1, ALLRED);
        49:  chk("k49_ph1", phase1, NIGHT);
        50:  chk("k50_l1", lights1, 6'b010101);
        51:  chk("k51_l1", lights1, 6'b111111);
        60:  night1 = 1'b0;
        61:  begin chk("k61_ph1", phase1, RESET); chk("k61_l1", lights1, 6'b000000); end
        62:  begin chk("k62_ph1", phase1, READY); chk("k62_dir1", dir1, 2'd0); ped1 = 3'b001; end
        70:  begin chk("k70_ph1", phase1, GO); chk("k70_w1", walk1, 3'b001); ped1 = 3'b000; end
        80:  begin chk("k80_ph0", phase0, GO); chk("k80_w0", walk0, 2'b00); end
        81:  chk("k81_ph0", phase0, STOP);
        90:  night0 = 1'b1;
        94:  begin chk("k94_ph1", phase1, GO); chk("k94_w1", walk1, 3'b000); end
        95:  ped0 = 2'b10;
        96:  ped0 = 2'b00;
        98:  chk("k98_ph1", phase1, STOP);
        100: chk("k100_ph0", phase0, STOP);
        101: begin chk("k101_ph0", phase0, NIGHT); chk("k101_l0", lights0, 4'b0101); end
        102: chk("k102_l0", lights0, 4'b1111);
        104: ped0 = 2'b01;
        105: ped0 = 2'b00;
        106: night0 = 1'b0;
        107: begin chk("k107_ph0", phase0, RESET); chk("k107_l0", lights0, 4'b0000); end
        108: begin chk("k108_ph0", phase0, READY); chk("k108_dir0", dir0, 1'b0); end
        111: begin chk("k111_ph0", phase0, GO); chk("k111_w0", walk0, 2'b00); end
        130: begin chk("k130_dir0", dir0, 1'b1); chk("k130_w0", walk0, 2'b00); end
        145: chk("k145_ph0", phase0, STOP);
        175: begin
          chk("k175_ph0", phase0, GO);
          chk("k175_dir0", dir0, 1'b1);
          #2 reset_n = 1'b0;
          #1;
          chk("arst_ph0", phase0, RESET);
          chk("arst_l0", lights0, 4'b0000);
          chk("arst_w0", walk0, 2'b00);
          chk("arst_dir0", dir0, 1'b0);
          chk("arst_ph1", phase1, RESET);
        end
        178: begin chk("k178_ph0", phase0, RESET); reset_n = 1'b1; end
        179: begin chk("k179_ph0", phase0, READY); chk("k179_dir0", dir0, 1'b0); end
        182: chk("k182_ph0", phase0, GO);
        default: ;
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
